apb_slave_mem: RTL

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_slave_mem_if.sv | 41 ++++
 rtl/apb_slave_mem.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem_if.sv
// ---------------------------------------------------------------------------
// apb_slave_mem_if
// Bundle of APB bus signals shared between an APB master and the
// apb_slave_mem storage slave. The clock and reset are not part of the
// bundle; they stay plain ports on the modules that use it.
//
// Signals:
//   pselx     master -> slave  slave select
//   penable   master -> slave  access-phase strobe
//   pwrite    master -> slave  1 = write, 0 = read
//   paddr     master -> slave  byte address (ADDR_WIDTH bits)
//   pwdata    master -> slave  write data (DATA_WIDTH bits)
//   wait_cfg  master -> slave  wait cycles to insert, sampled in setup phase
//   prdata    slave -> master  read data (DATA_WIDTH bits)
//   pready    slave -> master  transfer complete
//   pslverr   slave -> master  transfer error, meaningful while pready=1
// ---------------------------------------------------------------------------
interface apb_slave_mem_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  pselx;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [2:0]            wait_cfg;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output pselx, penable, pwrite, paddr, pwdata, wait_cfg,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  pselx, penable, pwrite, paddr, pwdata, wait_cfg,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_slave_mem.sv
// ---------------------------------------------------------------------------
// apb_slave_mem
// APB slave backed by a small word-addressed storage array. Each transfer
// may be stretched by a configurable number of wait cycles, and accesses
// that are misaligned or fall beyond the array report an error instead of
// touching storage.
//
// Ports:
//   pclk    input   APB clock, all logic on the rising edge
//   preset  input   synchronous active-high reset, clears state and storage
//   bus     slave   APB signal bundle (see apb_slave_mem_if)
//
// Parameters:
//   ADDR_WIDTH  APB address width
//   DATA_WIDTH  APB data width
//   MEM_DEPTH   number of DATA_WIDTH-bit words in the storage array
// ---------------------------------------------------------------------------
module apb_slave_mem #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 16
) (
   input logic            pclk,
   input logic            preset,
   apb_slave_mem_if.slave bus
);

   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      READY = 2'd2
   } stateT;

   stateT                 state;
   stateT                 nextState;

   logic [2:0]            waitCount;
   logic [IDX_W-1:0]      idxQ;
   logic                  writeQ;
   logic [DATA_WIDTH-1:0] wdataQ;
   logic                  errQ;
   logic [DATA_WIDTH-1:0] prdataQ;
   logic [DATA_WIDTH-1:0] memArray [MEM_DEPTH];

   logic                  setupSeen;
   logic                  liveErr;
   logic [IDX_W-1:0]      effIdx;
   logic                  effWrite;
   logic                  effErr;

   // Decode the live bus: a setup phase is select without enable, and the
   // address is flagged as bad when it is not word aligned or when its word
   // index lies past the end of the storage array.
   always_comb begin
      setupSeen = bus.pselx && !bus.penable;
      liveErr   = (bus.paddr[1:0] != 2'b00) ||
                  (bus.paddr[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(MEM_DEPTH));
   end

   // When a zero-wait transfer goes straight from IDLE to READY the request
   // has not been latched yet, so the read path must look at the live bus.
   // From WAIT the latched copy is the one that counts.
   always_comb begin
      if (state == IDLE) begin
         effIdx   = bus.paddr[IDX_W+1:2];
         effWrite = bus.pwrite;
         effErr   = liveErr;
      end else begin
         effIdx   = idxQ;
         effWrite = writeQ;
         effErr   = errQ;
      end
   end

   // State register. Reset wins over everything else, including a setup
   // phase presented in the same cycle, and abandons any transfer in flight.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. A setup phase with no wait cycles goes straight to
   // READY; otherwise WAIT runs until the counter reaches one. Dropping the
   // select during WAIT aborts the transfer. READY always lasts one cycle,
   // so a setup phase in the cycle after it is seen from IDLE without loss.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (setupSeen) begin
               nextState = (bus.wait_cfg == 3'd0) ? READY : WAIT;
            end
         end
         WAIT: begin
            if (!bus.pselx) begin
               nextState = IDLE;
            end else if (waitCount <= 3'd1) begin
               nextState = READY;
            end
         end
         READY: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Outputs come straight from flops: pready marks the READY state and the
   // error flag is only ever shown alongside it, so pslverr is low whenever
   // pready is low.
   always_comb begin
      bus.pready  = (state == READY);
      bus.pslverr = (state == READY) && errQ;
      bus.prdata  = prdataQ;
   end

   // Request latch, wait counter, read-data register and storage. Read data
   // is loaded on the edge entering READY so it is valid for the whole READY
   // cycle and then simply holds. Writes commit on the edge that ends READY,
   // which means a reset during WAIT or READY drops the write, and a
   // back-to-back read sees the new value.
   always_ff @(posedge pclk) begin
      if (preset) begin
         waitCount <= 3'd0;
         idxQ      <= '0;
         writeQ    <= 1'b0;
         wdataQ    <= '0;
         errQ      <= 1'b0;
         prdataQ   <= '0;
         for (int i = 0; i < MEM_DEPTH; i++) begin
            memArray[i] <= '0;
         end
      end else begin
         if (state == IDLE && setupSeen) begin
            idxQ      <= bus.paddr[IDX_W+1:2];
            writeQ    <= bus.pwrite;
            wdataQ    <= bus.pwdata;
            errQ      <= liveErr;
            waitCount <= bus.wait_cfg;
         end else if (state == WAIT) begin
            waitCount <= waitCount - 3'd1;
         end

         if (nextState == READY && !effWrite) begin
            prdataQ <= effErr ? '0 : memArray[effIdx];
         end

         if (state == READY && writeQ && !errQ) begin
            memArray[idxQ] <= wdataQ;
         end
      end
   end

endmodule
